// File: rtl/muldiv_engine.sv
// -----------------------------------------------------------------------------
// muldiv_engine
//   Iterative multiply/divide engine producing a HI/LO result pair.
//   Signed and unsigned multiply use shift-add over a 2*WIDTH accumulator.
//   Signed and unsigned divide use restoring division, one quotient bit per
//   cycle. A divide by zero is flagged on div0 and leaves HI/LO untouched.
//
//   Optional build macro: MULDIV_FAST_MULT_EN
//     When defined, MULT/MULTU use a single-cycle combinational multiplier.
//     When undefined, multiply is iterative and no hardware multiplier exists.
//
// Parameters:
//   WIDTH  operand width (>= 2); HI and LO are each WIDTH bits
//
// Ports:
//   clock  in   system clock, rising-edge active
//   reset  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   multiplicand / dividend
//   b      in   multiplier / divisor
//   busy   out  operation in flight
//   done   out  one-cycle completion pulse
//   div0   out  one-cycle divide-by-zero pulse, coincident with done
//   hi     out  upper product / remainder
//   lo     out  lower product / quotient
// -----------------------------------------------------------------------------
module muldiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 op_div_r;
  logic                 neg_q_r;      // negate product / quotient
  logic                 neg_r_r;      // negate remainder (dividend negative)
  logic                 div0_pend_r;
  logic [WIDTH:0]       mag_a_r;
  logic [WIDTH:0]       mag_b_r;
  logic [2*WIDTH-1:0]   acc_r;        // mult: {partial, multiplier}; div: {rem, quo}
  logic                 busy_r;
  logic                 done_r;
  logic                 div0_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 sgn_op_s;
  logic [WIDTH:0]       a_ext_s;
  logic [WIDTH:0]       b_ext_s;
  logic [WIDTH:0]       abs_a_s;
  logic [WIDTH:0]       abs_b_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       shifted_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

`ifdef MULDIV_FAST_MULT_EN
  logic                 fast_r;
  logic [2*WIDTH-1:0]   fast_prod_s;
  logic [2*WIDTH-1:0]   fast_fix_s;

  // Single-cycle magnitude product with sign correction for the fast path
  always_comb begin
    fast_prod_s = {ZERO_W, mag_a_r[WIDTH-1:0]} * {ZERO_W, mag_b_r[WIDTH-1:0]};
    if (neg_q_r) begin
      fast_fix_s = ZERO_2W - fast_prod_s;
    end else begin
      fast_fix_s = fast_prod_s;
    end
  end
`endif

  // Operand magnitudes; the extra bit keeps the most negative value exact
  always_comb begin
    sgn_op_s = ~op[0];
    a_ext_s  = {sgn_op_s & a[WIDTH-1], a};
    b_ext_s  = {sgn_op_s & b[WIDTH-1], b};
    if (sgn_op_s && a[WIDTH-1]) begin
      abs_a_s = ZERO_W1 - a_ext_s;
    end else begin
      abs_a_s = a_ext_s;
    end
    if (sgn_op_s && b[WIDTH-1]) begin
      abs_b_s = ZERO_W1 - b_ext_s;
    end else begin
      abs_b_s = b_ext_s;
    end
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? mag_a_r : ZERO_W1);
    shifted_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    if (op_div_r) begin
      // The difference is below the divisor, so it always fits in WIDTH bits
      if (shifted_s >= mag_b_r) begin
        acc_next_s = {shifted_s[WIDTH-1:0] - mag_b_r[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    if (neg_q_r) begin
      prod_fix_s = ZERO_2W - acc_r;
      quo_fix_s  = ZERO_W - acc_r[WIDTH-1:0];
    end else begin
      prod_fix_s = acc_r;
      quo_fix_s  = acc_r[WIDTH-1:0];
    end
    if (neg_r_r) begin
      rem_fix_s = ZERO_W - acc_r[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered outputs and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= ZERO_CNT;
      op_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      div0_pend_r <= 1'b0;
      mag_a_r     <= ZERO_W1;
      mag_b_r     <= ZERO_W1;
      acc_r       <= ZERO_2W;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div0_r      <= 1'b0;
      hi_r        <= ZERO_W;
      lo_r        <= ZERO_W;
`ifdef MULDIV_FAST_MULT_EN
      fast_r      <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_div_r <= op[1];
            mag_a_r  <= abs_a_s;
            mag_b_r  <= abs_b_s;
            neg_q_r  <= sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r  <= sgn_op_s & op[1] & a[WIDTH-1];
            cnt_r    <= ZERO_CNT;
            busy_r   <= 1'b1;
            // Divide seeds the dividend as the quotient shifter; multiply the multiplier
            if (op[1]) begin
              acc_r <= {ZERO_W, abs_a_s[WIDTH-1:0]};
            end else begin
              acc_r <= {ZERO_W, abs_b_s[WIDTH-1:0]};
            end
            if (op[1] && (b == ZERO_W)) begin
              state_r     <= S_DONE;
              div0_pend_r <= 1'b1;
            end
`ifdef MULDIV_FAST_MULT_EN
            else if (!op[1]) begin
              state_r <= S_DONE;
              fast_r  <= 1'b1;
            end
`endif
            else begin
              state_r <= S_RUN;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_r <= acc_next_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= ZERO_CNT;
            state_r <= S_FIX;
          end else begin
            cnt_r   <= cnt_r + ONE_CNT;
            state_r <= S_RUN;
          end
        end
        S_FIX: begin
          if (op_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
          state_r <= S_DONE;
        end
        S_DONE: begin
          done_r      <= 1'b1;
          div0_r      <= div0_pend_r;
          div0_pend_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
`ifdef MULDIV_FAST_MULT_EN
          if (fast_r) begin
            hi_r <= fast_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= fast_fix_s[WIDTH-1:0];
          end
          fast_r <= 1'b0;
`endif
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign div0 = div0_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_engine.sv
// -----------------------------------------------------------------------------
// tb_muldiv_engine
//   Scoreboard bench for muldiv_engine (WIDTH = 32). The driver pushes the
//   expected HI/LO/div0 and latency when it issues a start; a monitor on the
//   falling edge pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_engine;

  localparam int W = 32;

`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 2;
`endif
  localparam int LAT_DIV  = W + 2;
  localparam int LAT_DIV0 = 1;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   checks;
  int   failures;

  muldiv_engine #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (div0 === 1'b1 && done !== 1'b1) begin
        chk("div0_without_done", {63'd0, done}, 64'd1);
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("div0", {63'd0, div0}, {63'd0, e.div0});
          chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input int lat, input bit disturb);
    exp_t e;
    @(negedge clock);
    op    = o;
    a     = aa;
    b     = bb;
    start = 1'b1;
    e.hi = eh; e.lo = el; e.div0 = ed; e.start_cyc = cyc + 1; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    a     = 32'h1234_5678;
    b     = 32'h0000_0003;
    op    = 2'b01;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    if (disturb) begin
      repeat (4) @(negedge clock);
      op    = 2'b00;
      a     = 32'h0000_0011;
      b     = 32'h0000_0013;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      chk("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT_MUL, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_MUL, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, LAT_MUL, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_DIV, 1'b0);
    do_op(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, LAT_DIV, 1'b1);
    do_op(2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h0000_0003, 1'b1, LAT_DIV0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, LAT_DIV, 1'b0);
    do_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, LAT_MUL, 1'b0);

    // Abort: start, ignored second start at cycle 5, reset at cycle 10
    @(negedge clock);
    op    = 2'b00;
    a     = 32'h0000_0005;
    b     = 32'h0000_0006;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    a     = 32'h0000_0009;
    b     = 32'h0000_0009;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (45) @(negedge clock);
    chk("post_abort_busy", {63'd0, busy}, 64'd0);
    chk("post_abort_lo", {32'd0, lo}, 64'd0);

    do_op(2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, LAT_MUL, 1'b0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
